// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming convolution datapath:
// sequencer FSM encoding, register-file offsets and global size limits.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_RESET     = 4;
    localparam int unsigned REG_WIDTH     = 16;
    localparam int unsigned REG_HEIGHT    = 20;
    localparam int unsigned REG_COEF_BASE = 24;

    localparam int unsigned MAX_KERNEL   = 7;
    localparam int unsigned MAX_CHANNELS = 16;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Pixel stream bundle around the window sequencer: the AXI4-Stream input,
// the tagged AXI4-Stream output and the per-beat position/window tags.
interface conv_window_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 11,
    parameter int CHAN_WIDTH = 1
);
    logic                  s_axis_valid;
    logic                  s_axis_ready;
    logic [DATA_WIDTH-1:0] s_axis_data;
    logic                  s_axis_last;

    logic                  m_axis_valid;
    logic                  m_axis_ready;
    logic [DATA_WIDTH-1:0] m_axis_data;
    logic                  m_axis_last;
    logic [DIM_WIDTH-1:0]  m_row;
    logic [DIM_WIDTH-1:0]  m_col;
    logic [CHAN_WIDTH-1:0] m_chan;
    logic                  m_win_valid;

    // Environment side: pixel source upstream, line buffer / MAC array downstream.
    modport master (
        output s_axis_valid, s_axis_data, s_axis_last, m_axis_ready,
        input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
               m_row, m_col, m_chan, m_win_valid
    );

    // Sequencer side.
    modport slave (
        input  s_axis_valid, s_axis_data, s_axis_last, m_axis_ready,
        output s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
               m_row, m_col, m_chan, m_win_valid
    );

endinterface

// File: rtl/conv_pos_counter.sv
// Channel/column/row position counters with stride phase tracking and the
// window-valid decode for the pixel currently presented at the input.
module conv_pos_counter #(
    parameter int CHANNELS    = 1,
    parameter int KERNEL_SIZE = 3,
    parameter int DIM_WIDTH   = 11,
    parameter int STRIDE_W    = 3,
    parameter int CHAN_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 adv,
    input  logic [DIM_WIDTH-1:0] width,
    input  logic [DIM_WIDTH-1:0] height,
    input  logic [STRIDE_W-1:0]  stride,
    output logic [CHAN_W-1:0]    chan,
    output logic [DIM_WIDTH-1:0] row,
    output logic [DIM_WIDTH-1:0] col,
    output logic                 win_valid,
    output logic                 pix_last,
    output logic                 frame_end
);

    localparam logic [DIM_WIDTH-1:0] K_M1     = DIM_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CHAN_W-1:0]    CHAN_MAX = CHAN_W'(CHANNELS - 1);

    logic [STRIDE_W-1:0]  col_ph, row_ph;
    logic [STRIDE_W-1:0]  col_ph_nxt, row_ph_nxt;
    logic [STRIDE_W-1:0]  ph_max;
    logic [DIM_WIDTH-1:0] col_nxt, row_nxt;
    logic                 col_last, row_last;

    assign ph_max    = stride - STRIDE_W'(1);
    assign col_nxt   = col + DIM_WIDTH'(1);
    assign row_nxt   = row + DIM_WIDTH'(1);
    assign pix_last  = (chan == CHAN_MAX);
    assign col_last  = (col == width - DIM_WIDTH'(1));
    assign row_last  = (row == height - DIM_WIDTH'(1));
    assign frame_end = pix_last && col_last && row_last;

    assign win_valid = (row >= K_M1) && (col >= K_M1) &&
                       (col_ph == '0) && (row_ph == '0);

    // Phase restarts where the first full window fits, then counts modulo stride
    // by wrapping at stride-1; its value before that point is never consulted.
    always_comb begin
        col_ph_nxt = col_ph + STRIDE_W'(1);
        row_ph_nxt = row_ph + STRIDE_W'(1);
        if (col_nxt == K_M1 || col_ph == ph_max) col_ph_nxt = '0;
        if (row_nxt == K_M1 || row_ph == ph_max) row_ph_nxt = '0;
    end

    // NOTE: state registers use non-blocking assignments so every counter
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan   <= '0;
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (clr) begin
            chan   <= '0;
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (adv) begin
            if (!pix_last) begin
                chan <= chan + CHAN_W'(1);
            end else begin
                chan <= '0;
                if (!col_last) begin
                    col    <= col_nxt;
                    col_ph <= col_ph_nxt;
                end else begin
                    col    <= '0;
                    col_ph <= '0;
                    row    <= row_nxt;
                    row_ph <= row_ph_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame/window sequencer: one register stage that tags each pixel beat with its
// position and window validity. Optional CONV_SEQ_FRAME_CHECK_EN adds frame-length checking.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNELS    = 1,
    parameter int KERNEL_SIZE = 3,
    parameter int DIM_WIDTH   = 11,
    parameter int STRIDE_MAX  = 4,
    localparam int STRIDE_W   = $clog2(STRIDE_MAX + 1),
    localparam int CHAN_W     = $clog2(CHANNELS) + 1
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     soft_rst,
    input  logic                     cfg_enable,
    input  logic [DIM_WIDTH-1:0]     cfg_width,
    input  logic [DIM_WIDTH-1:0]     cfg_height,
    input  logic [STRIDE_W-1:0]      cfg_stride,
    conv_window_sequencer_if.slave   bus,
    output logic                     frame_done,
    output logic [2*DIM_WIDTH-1:0]   win_count,
`ifdef CONV_SEQ_FRAME_CHECK_EN
    output logic [1:0]               frame_err,
`endif
    output logic                     busy
);

    localparam logic [DIM_WIDTH-1:0] K_DIM = DIM_WIDTH'(KERNEL_SIZE);
    localparam logic [STRIDE_W-1:0]  S_MAX = STRIDE_W'(STRIDE_MAX);

    seq_state_e state_q, state_d;

    logic [DIM_WIDTH-1:0]   lat_width, lat_height;
    logic [STRIDE_W-1:0]    lat_stride;
    logic                   cfg_legal, start, accept, flush_done, frame_end_hit;
    logic                   s_ready;

    logic [CHAN_W-1:0]      pos_chan;
    logic [DIM_WIDTH-1:0]   pos_row, pos_col;
    logic                   pos_win, pos_pix_last, pos_frame_end;

    logic                   out_valid, out_last, out_win;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [DIM_WIDTH-1:0]   out_row, out_col;
    logic [CHAN_W-1:0]      out_chan;
    logic [2*DIM_WIDTH-1:0] win_cnt_q;

    assign cfg_legal  = (cfg_width >= K_DIM) && (cfg_height >= K_DIM) &&
                        (cfg_stride != '0) && (cfg_stride <= S_MAX);
    assign start      = (state_q == ST_IDLE) && cfg_enable && cfg_legal;
    assign accept     = s_ready && bus.s_axis_valid;
    assign flush_done = (state_q == ST_FLUSH) && !out_valid;

`ifdef CONV_SEQ_FRAME_CHECK_EN
    assign frame_end_hit = pos_frame_end || bus.s_axis_last;
`else
    logic unused_s_last;
    assign unused_s_last = bus.s_axis_last;
    assign frame_end_hit = pos_frame_end;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)  state_q <= ST_IDLE;
        else if (soft_rst) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational blocks assign every output a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && frame_end_hit) state_d = ST_FLUSH;
            ST_FLUSH: if (!out_valid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_ready    = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_RUN: begin
                s_ready = !out_valid || bus.m_axis_ready;
                busy    = 1'b1;
            end
            ST_FLUSH: begin
                busy       = 1'b1;
                frame_done = !out_valid && !soft_rst;
            end
            default: ;
        endcase
    end

    assign bus.s_axis_ready = s_ready;

    // Configuration is captured only on IDLE->RUN; soft_rst leaves it intact.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            lat_width  <= '0;
            lat_height <= '0;
            lat_stride <= '0;
        end else if (start && !soft_rst) begin
            lat_width  <= cfg_width;
            lat_height <= cfg_height;
            lat_stride <= cfg_stride;
        end
    end

    conv_pos_counter #(
        .CHANNELS    (CHANNELS),
        .KERNEL_SIZE (KERNEL_SIZE),
        .DIM_WIDTH   (DIM_WIDTH),
        .STRIDE_W    (STRIDE_W),
        .CHAN_W      (CHAN_W)
    ) u_pos (
        .clk       (axi_clk),
        .rst_n     (axi_reset_n),
        .clr       (soft_rst || flush_done),
        .adv       (accept),
        .width     (lat_width),
        .height    (lat_height),
        .stride    (lat_stride),
        .chan      (pos_chan),
        .row       (pos_row),
        .col       (pos_col),
        .win_valid (pos_win),
        .pix_last  (pos_pix_last),
        .frame_end (pos_frame_end)
    );

    // NOTE: the payload registers are reset too, because every output must read
    // zero after reset or soft_rst, not only the valid flag.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_chan  <= '0;
        end else if (soft_rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= frame_end_hit;
            out_win   <= pos_win;
            out_data  <= bus.s_axis_data;
            out_row   <= pos_row;
            out_col   <= pos_col;
            out_chan  <= pos_chan;
        end else if (bus.m_axis_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.m_axis_valid = out_valid;
    assign bus.m_axis_last  = out_last;
    assign bus.m_axis_data  = out_data;
    assign bus.m_row        = out_row;
    assign bus.m_col        = out_col;
    assign bus.m_chan       = out_chan;
    assign bus.m_win_valid  = out_win;

    // A window is counted once, on the final channel beat of its pixel.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            win_cnt_q <= '0;
            win_count <= '0;
        end else if (soft_rst) begin
            win_cnt_q <= '0;
            win_count <= '0;
        end else if (flush_done) begin
            win_cnt_q <= '0;
            win_count <= win_cnt_q;
        end else if (accept && pos_win && pos_pix_last) begin
            win_cnt_q <= win_cnt_q + (2*DIM_WIDTH)'(1);
        end
    end

`ifdef CONV_SEQ_FRAME_CHECK_EN
    // Sticky {late, early}: last flag missing on the expected final beat, or early.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            frame_err <= '0;
        end else if (soft_rst) begin
            frame_err <= '0;
        end else if (accept) begin
            if (bus.s_axis_last && !pos_frame_end) frame_err[0] <= 1'b1;
            if (pos_frame_end && !bus.s_axis_last) frame_err[1] <= 1'b1;
        end
    end
`endif

endmodule
